// File: rtl/jt10_adpcm_romarb.sv
// jt10_adpcm_romarb
// Shares one external sample-ROM read port between the YM2610 ADPCM-A and
// ADPCM-B fetchers. Each requester has a one-byte tagged cache. A ROM read
// is issued only when a requester's address differs from its tag.
// Simultaneous misses are served round-robin. Each requester is mapped
// into its own ROM region.
//
// ROM handshake: rom_cs is a request. It rises with rom_addr already valid
// and stays high, with rom_addr stable, until the first clock edge at which
// rom_ok is high. rom_data is sampled on that same edge and rom_cs drops
// after it. rom_ok outside a request is ignored. After every request rom_cs
// is low for at least one clock.
module jt10_adpcm_romarb #(
    parameter int              AW     = 25,
    parameter logic [AW-1:0]   A_BASE = 25'h000_0000,
    parameter logic [AW-1:0]   B_BASE = 25'h100_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    // ADPCM-A side
    input  logic [23:0]   a_addr,
    input  logic          a_roe_n,
    output logic [7:0]    a_data,
    output logic          a_ok,
    // ADPCM-B side
    input  logic [23:0]   b_addr,
    input  logic          b_roe_n,
    output logic [7:0]    b_data,
    output logic          b_ok,
    // external ROM port
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    // FSM state for observation: 0 idle, 1 serving A, 2 serving B
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    state_t      state;
    logic        prio_b;      // tie-break winner: 0 = A, 1 = B
    logic [23:0] fetch_tag;   // address of the fetch in flight
    logic [23:0] tag_a;
    logic [23:0] tag_b;
    logic        valid_a;
    logic        valid_b;
    logic        miss_a;
    logic        miss_b;
    logic        grant_b;

    // Hit flags compare the live address with the stored tag, so a changed
    // address drops the ok flag within the same cycle.
    assign a_ok   = valid_a & (a_addr == tag_a);
    assign b_ok   = valid_b & (b_addr == tag_b);
    assign miss_a = ~a_roe_n & ~a_ok;
    assign miss_b = ~b_roe_n & ~b_ok;

    // B wins when it misses alone, or when both miss and it is B's turn.
    assign grant_b = miss_b & (~miss_a | prio_b);

    assign state_dbg = state;

    // Arbitration FSM. It issues one ROM request at a time and loads the
    // cache of the requester that owns the returning byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio_b    <= 1'b0;
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
            fetch_tag <= '0;
            tag_a     <= '0;
            tag_b     <= '0;
            valid_a   <= 1'b0;
            valid_b   <= 1'b0;
            a_data    <= '0;
            b_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_a || miss_b) begin
                        rom_cs <= 1'b1;
                        if (grant_b) begin
                            rom_addr  <= B_BASE + AW'(b_addr);
                            fetch_tag <= b_addr;
                            state     <= BUSY_B;
                        end else begin
                            rom_addr  <= A_BASE + AW'(a_addr);
                            fetch_tag <= a_addr;
                            state     <= BUSY_A;
                        end
                    end
                end
                BUSY_A: begin
                    // The tag is the address that was fetched, not the
                    // current one. A moved address then simply misses again.
                    if (rom_ok) begin
                        a_data  <= rom_data;
                        tag_a   <= fetch_tag;
                        valid_a <= 1'b1;
                        rom_cs  <= 1'b0;
                        prio_b  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                BUSY_B: begin
                    if (rom_ok) begin
                        b_data  <= rom_data;
                        tag_b   <= fetch_tag;
                        valid_b <= 1'b1;
                        rom_cs  <= 1'b0;
                        prio_b  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    rom_cs <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt10_adpcm_romarb.sv
// tb_jt10_adpcm_romarb
// Directed scenarios plus random traffic for jt10_adpcm_romarb. A
// transaction-level model tracks each requester's cached byte and predicts
// every ROM fetch. Predicted fetch addresses go into exp_q and are popped as
// the DUT raises rom_cs.
module tb_jt10_adpcm_romarb;

    localparam int            AW      = 25;
    localparam logic [AW-1:0] A_BASE  = 25'h000_0000;
    localparam logic [AW-1:0] B_BASE  = 25'h100_0000;
    localparam logic [AW-1:0] B_BASE2 = 25'h1FF_FFFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    // main DUT
    logic [23:0]   a_addr = '0, b_addr = '0;
    logic          a_roe_n = 1'b1, b_roe_n = 1'b1;
    logic [7:0]    a_data, b_data;
    logic          a_ok, b_ok;
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data = '0;
    logic          rom_ok = 1'b0;
    logic [1:0]    state_dbg;

    // second DUT with a B base that forces address wrap-around
    logic [23:0]   a2_addr = '0, b2_addr = '0;
    logic          a2_roe_n = 1'b1, b2_roe_n = 1'b1;
    logic [7:0]    a2_data, b2_data;
    logic          a2_ok, b2_ok;
    logic [AW-1:0] rom_addr2;
    logic          rom_cs2;
    logic [7:0]    rom_data2 = '0;
    logic          rom_ok2 = 1'b0;
    logic [1:0]    state_dbg2;

    jt10_adpcm_romarb #(.AW(AW), .A_BASE(A_BASE), .B_BASE(B_BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_addr(a_addr), .a_roe_n(a_roe_n), .a_data(a_data), .a_ok(a_ok),
        .b_addr(b_addr), .b_roe_n(b_roe_n), .b_data(b_data), .b_ok(b_ok),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .state_dbg(state_dbg)
    );

    jt10_adpcm_romarb #(.AW(AW), .A_BASE(A_BASE), .B_BASE(B_BASE2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .a_addr(a2_addr), .a_roe_n(a2_roe_n), .a_data(a2_data), .a_ok(a2_ok),
        .b_addr(b2_addr), .b_roe_n(b2_roe_n), .b_data(b2_data), .b_ok(b2_ok),
        .rom_addr(rom_addr2), .rom_cs(rom_cs2), .rom_data(rom_data2), .rom_ok(rom_ok2),
        .state_dbg(state_dbg2)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_bad    = 0;
    logic [AW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ROM contents seen by the bench: a fixed function of the byte address
    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        return (a[7:0] ^ a[15:8] ^ a[23:16] ^ {7'd0, a[24]}) + 8'h5A;
    endfunction

    // ---------------- reference model ----------------
    // Requester 0 is A, requester 1 is B.
    logic [23:0]   m_tag[2];
    logic          m_valid[2];
    logic [7:0]    m_data[2];
    logic [AW-1:0] m_base[2];
    logic          m_busy;
    int            m_own;
    int            m_next;    // who wins when both miss
    logic [23:0]   m_ftag;
    logic [AW-1:0] m_addr;

    // inputs as they were held across the most recent rising edge
    logic        p_rst = 1'b0;
    logic [23:0] p_a_addr, p_b_addr;
    logic        p_a_roe, p_b_roe, p_rom_ok;
    logic [7:0]  p_rom_data;

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            m_tag[r]   = '0;
            m_valid[r] = 1'b0;
            m_data[r]  = '0;
        end
        m_base[0] = A_BASE;
        m_base[1] = B_BASE;
        m_busy    = 1'b0;
        m_own     = 0;
        m_next    = 0;
        m_ftag    = '0;
        m_addr    = '0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge.
    task automatic model_step();
        logic [23:0] addr[2];
        logic        roe_n[2];
        logic        miss[2];
        int          win;
        if (!p_rst) return;
        if (m_busy) begin
            if (p_rom_ok) begin
                m_tag[m_own]   = m_ftag;
                m_valid[m_own] = 1'b1;
                m_data[m_own]  = p_rom_data;
                m_busy         = 1'b0;
                m_next         = 1 - m_own;
            end
        end else begin
            addr[0] = p_a_addr;  addr[1] = p_b_addr;
            roe_n[0] = p_a_roe;  roe_n[1] = p_b_roe;
            for (int r = 0; r < 2; r++)
                miss[r] = !roe_n[r] && !(m_valid[r] && m_tag[r] == addr[r]);
            if (miss[0] || miss[1]) begin
                if (miss[0] && miss[1]) win = m_next;
                else                    win = miss[1] ? 1 : 0;
                m_busy = 1'b1;
                m_own  = win;
                m_ftag = addr[win];
                m_addr = m_base[win] + AW'(addr[win]);
                exp_q.push_back(m_addr);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    int   rom_wait  = -1;
    int   ok_delay  = 2;
    logic rom_auto  = 1'b1;
    logic ovr_en    = 1'b0;
    logic [7:0] ovr_data = '0;
    logic last_cs   = 1'b0;
    int   fetch_cnt = 0;
    int   grants[$];

    // Negative edge: advance the model, then check registered outputs.
    task automatic tick();
        @(negedge clk);
        model_step();
        if (rom_cs && !last_cs) begin
            fetch_cnt++;
            grants.push_back(int'(rom_addr >= B_BASE));
            check_eq("fetch_predicted", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check_eq("fetch_addr", rom_addr, exp_q.pop_front());
        end
        last_cs = rom_cs;
        check_eq("rom_cs", rom_cs, m_busy);
        if (m_busy) check_eq("rom_addr_hold", rom_addr, m_addr);
        check_eq("a_data", a_data, m_data[0]);
        check_eq("b_data", b_data, m_data[1]);
        check_eq("state_busy", 32'(state_dbg != 2'd0), m_busy);
    endtask

    // After the caller drives inputs: the ROM responder acts, combinational
    // ok flags are checked, and the held inputs are recorded for the model.
    task automatic settle();
        if (rom_auto) begin
            rom_ok = 1'b0;
            if (rom_cs) begin
                if (rom_wait < 0) rom_wait = ok_delay;
                if (rom_wait == 0) begin
                    rom_ok   = 1'b1;
                    rom_data = ovr_en ? ovr_data : rom_byte(rom_addr);
                    rom_wait = -1;
                end else begin
                    rom_wait--;
                end
            end
        end
        #1;
        check_eq("a_ok", a_ok, m_valid[0] && m_tag[0] == a_addr);
        check_eq("b_ok", b_ok, m_valid[1] && m_tag[1] == b_addr);
        p_rst      = rst_n;
        p_a_addr   = a_addr;
        p_b_addr   = b_addr;
        p_a_roe    = a_roe_n;
        p_b_roe    = b_roe_n;
        p_rom_ok   = rom_ok;
        p_rom_data = rom_data;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            settle();
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rom_ok   = 1'b0;
        rom_wait = -1;
        #1;
        check_eq("rst_rom_cs", rom_cs, 0);
        check_eq("rst_rom_addr", rom_addr, 0);
        check_eq("rst_a_ok", a_ok, 0);
        check_eq("rst_b_ok", b_ok, 0);
        check_eq("rst_a_data", a_data, 0);
        check_eq("rst_b_data", b_data, 0);
        model_reset();
        settle();
        tick();
        settle();
        tick();
        rst_n = 1'b1;
        settle();
    endtask

    task automatic wait_fetch(input string tag);
        int start = fetch_cnt;
        int k = 0;
        while (fetch_cnt == start && k < 30) begin
            tick();
            settle();
            k++;
        end
        check_eq(tag, 32'(fetch_cnt != start), 1);
    endtask

    task automatic wait_ok(input int r, input string tag);
        int k = 0;
        while (!(r == 0 ? a_ok : b_ok) && k < 40) begin
            tick();
            settle();
            k++;
        end
        check_eq(tag, (r == 0) ? a_ok : b_ok, 1);
    endtask

    function automatic logic [23:0] pick_addr();
        logic [23:0] pool[5];
        pool[0] = 24'h000000; pool[1] = 24'h000001; pool[2] = 24'hFFFFFF;
        pool[3] = 24'h012345; pool[4] = 24'h0ABCDE;
        if ($urandom_range(0, 5) == 5) return 24'($urandom);
        return pool[$urandom_range(0, 4)];
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int snap;
        int k;
        logic [AW-1:0] exp2;

        @(negedge clk);
        do_reset();

        // single miss on A, ROM answers 3 clocks later with 0xA5
        ovr_en = 1'b1; ovr_data = 8'hA5; ok_delay = 3;
        tick(); a_roe_n = 1'b0; a_addr = 24'h012345; settle();
        tick();
        check_eq("t1_rom_cs", rom_cs, 1);
        check_eq("t1_rom_addr", rom_addr, 25'h0012345);
        settle();
        wait_ok(0, "t1_a_ok");
        check_eq("t1_a_data", a_data, 8'hA5);
        check_eq("t1_b_ok", b_ok, 0);
        ovr_en = 1'b0;

        // hit is held: no new fetch; then +1 drops ok at once and refetches once
        snap = fetch_cnt;
        run(100);
        check_eq("t2_no_refetch", fetch_cnt - snap, 0);
        check_eq("t2_a_ok_held", a_ok, 1);
        tick(); a_addr = a_addr + 24'd1; #1;
        check_eq("t2_a_ok_drop", a_ok, 0);
        settle();
        run(15);
        check_eq("t2_one_fetch", fetch_cnt - snap, 1);
        check_eq("t2_a_ok_again", a_ok, 1);

        // address moves while a fetch is in flight
        ok_delay = 4;
        tick(); a_addr = 24'h000100; settle();
        wait_fetch("t3_fetch1");
        check_eq("t3_addr1", rom_addr, 25'h0000100);
        tick(); a_addr = 24'h000200; settle();
        k = 0;
        do begin
            tick();
            if (rom_cs) check_eq("t3_addr_stable", rom_addr, 25'h0000100);
            check_eq("t3_a_ok_low", a_ok, 0);
            settle();
            k++;
        end while (rom_cs && k < 20);
        wait_fetch("t3_fetch2");
        check_eq("t3_addr2", rom_addr, 25'h0000200);
        wait_ok(0, "t3_a_ok");

        // reset during a B fetch; a late rom_ok must be ignored
        ok_delay = 10;
        tick(); b_roe_n = 1'b0; b_addr = 24'h000ABC; settle();
        wait_fetch("t4_fetch");
        check_eq("t4_addr", rom_addr, 25'h1000ABC);
        tick();
        a_roe_n = 1'b1; b_roe_n = 1'b1; rom_auto = 1'b0;
        do_reset();
        snap = fetch_cnt;
        tick(); settle();
        tick(); rom_ok = 1'b1; rom_data = 8'h77; settle();
        tick(); rom_ok = 1'b0; settle();
        run(3);
        check_eq("t4_b_data", b_data, 0);
        check_eq("t4_b_ok", b_ok, 0);
        check_eq("t4_idle", fetch_cnt - snap, 0);
        rom_auto = 1'b1;

        // both miss together after reset: A first, then B, then strict alternation
        ok_delay = 2;
        grants.delete();
        tick();
        a_addr = 24'h000010; b_addr = 24'h000020; a_roe_n = 1'b0; b_roe_n = 1'b0;
        settle();
        wait_fetch("t5_fetch_a");
        check_eq("t5_addr_a", rom_addr, 25'h0000010);
        wait_fetch("t5_fetch_b");
        check_eq("t5_addr_b", rom_addr, 25'h1000020);
        for (int i = 0; i < 150; i++) begin
            tick();
            if (a_ok) a_addr = a_addr + 24'd1;
            if (b_ok) b_addr = b_addr + 24'd1;
            settle();
        end
        check_eq("t5_grant_count", 32'(grants.size() >= 10), 1);
        for (int i = 0; i < grants.size(); i++)
            check_eq("t5_alternate", grants[i], i % 2);

        // top of the B region with the default base
        tick(); a_roe_n = 1'b1; b_addr = 24'hFFFFFF; settle();
        wait_fetch("t6_fetch");
        if (rom_addr[24:23] == 2'b10) wait_fetch("t6_fetch_next");
        check_eq("t6_addr", rom_addr, 25'h1FFFFFF);
        wait_ok(1, "t6_b_ok");

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            tick();
            ok_delay = $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) a_addr = pick_addr();
            if ($urandom_range(0, 3) == 0) b_addr = pick_addr();
            if ($urandom_range(0, 7) == 0) a_roe_n = ~a_roe_n;
            if ($urandom_range(0, 7) == 0) b_roe_n = ~b_roe_n;
            settle();
        end

        // B base at the top of the ROM: sums wrap modulo 2^25.
        // 0x1FFFFFF + 0xFFFFFF = 0x2FFFFFE, which keeps 0x0FFFFFE in 25 bits.
        @(negedge clk); b2_addr = 24'hFFFFFF; b2_roe_n = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!rom_cs2 && k < 10);
        check_eq("w_rom_cs", rom_cs2, 1);
        exp2 = B_BASE2 + AW'(24'hFFFFFF);
        check_eq("w_addr_ffffff", rom_addr2, exp2);
        rom_ok2 = 1'b1; rom_data2 = 8'h3C;
        @(negedge clk); rom_ok2 = 1'b0;
        check_eq("w_b_ok", b2_ok, 1);
        check_eq("w_b_data", b2_data, 8'h3C);
        b2_addr = 24'h000001;
        k = 0;
        do begin @(negedge clk); k++; end while (!rom_cs2 && k < 10);
        check_eq("w_addr_000001", rom_addr2, 25'h0000000);
        rom_ok2 = 1'b1;
        @(negedge clk); rom_ok2 = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
